// File: rtl/bsr_ctrl_pkg.sv
// Shared types and constants for the bidirectional shift-register loopback controller.
package bsr_ctrl_pkg;

   localparam int BSR_WIDTH = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } bsr_state_t;

   typedef enum logic {
      DIR_L = 1'b0,
      DIR_R = 1'b1
   } bsr_dir_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The last-grant register moves only when a
// grant is issued, so a tie always goes to the channel that was not served last.
module rr_arb2
   import bsr_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req_r,
   input  logic req_l,
   output logic gnt_r,
   output logic gnt_l
);

   bsr_dir_t last_q;
   bsr_dir_t last_d;

   // Pick a winner when enabled and remember which channel it was.
   always_comb begin
      gnt_r  = 1'b0;
      gnt_l  = 1'b0;
      last_d = last_q;
      if (en && req_r && (!req_l || (last_q == DIR_L))) begin
         gnt_r  = 1'b1;
         last_d = DIR_R;
      end else if (en && req_l) begin
         gnt_l  = 1'b1;
         last_d = DIR_L;
      end else begin
         last_d = last_q;
      end
   end

   // Last-grant register; resets to L so the first tie goes to R.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= DIR_L;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/bsr_loopback_ctrl.sv
// Loopback sequencer for a bidirectional SISO shift register: arbitrates two
// requesters, clears the register, shifts the granted word in, drains it back
// out, and reports the reassembled word with a mismatch flag.
module bsr_loopback_ctrl
   import bsr_ctrl_pkg::*;
#(
   parameter int WIDTH = BSR_WIDTH
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             req_r,
   input  logic [WIDTH-1:0] data_r,
   input  logic             req_l,
   input  logic [WIDTH-1:0] data_l,
   output logic             gnt_r,
   output logic             gnt_l,
   output logic             sr_select,
   output logic             sr_serial_r,
   output logic             sr_serial_l,
   output logic             sr_clear_n,
   input  logic             sr_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_dir,
   output logic             err
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   bsr_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   bsr_dir_t         dir_q, dir_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             gnt_r_q, gnt_r_d, gnt_l_q, gnt_l_d;
   logic             sr_select_q, sr_select_d;
   logic             sr_serial_r_q, sr_serial_r_d;
   logic             sr_serial_l_q, sr_serial_l_d;
   logic             sr_clear_n_q, sr_clear_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             rx_dir_q, rx_dir_d;
   logic             err_q, err_d;

   logic             arb_en_s, arb_gnt_r_s, arb_gnt_l_s;
   logic [IW-1:0]    load_r_idx_s, load_l_idx_s;
   logic [IW-1:0]    drain_r_idx_s, drain_l_idx_s;

   // Arbitration is open in IDLE (except the grant cycle itself) and in DONE,
   // so back-to-back transfers can be granted the cycle after done.
   assign arb_en_s = ((state_q == IDLE) && !gnt_r_q && !gnt_l_q) || (state_q == DONE);

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (clear_n),
      .en    (arb_en_s),
      .req_r (req_r),
      .req_l (req_l),
      .gnt_r (arb_gnt_r_s),
      .gnt_l (arb_gnt_l_s)
   );

   // Sequence state and the shared LOAD/DRAIN down-counter (reloads on every state entry).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = (gnt_r_q || gnt_l_q) ? CLEAR : IDLE;
         CLEAR:   state_d = LOAD;
         LOAD:    state_d = (cnt_q == {CW{1'b0}}) ? DRAIN : LOAD;
         DRAIN:   state_d = (cnt_q == {CW{1'b0}}) ? DONE : DRAIN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         cnt_d = CW'(WIDTH - 1);
      end else if (cnt_q != {CW{1'b0}}) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Grant pulses and capture of the granted word and its direction.
   always_comb begin
      gnt_r_d = arb_gnt_r_s;
      gnt_l_d = arb_gnt_l_s;
      word_d  = word_q;
      dir_d   = dir_q;
      if (arb_gnt_r_s) begin
         word_d = data_r;
         dir_d  = DIR_R;
      end else if (arb_gnt_l_s) begin
         word_d = data_l;
         dir_d  = DIR_L;
      end else begin
         word_d = word_q;
         dir_d  = dir_q;
      end
   end

   // Bit indices: R moves LSB first, L moves MSB first. Load indices use the
   // next count because the serial outputs are registered one cycle ahead.
   assign load_r_idx_s  = IW'(CW'(WIDTH - 1) - cnt_d);
   assign load_l_idx_s  = IW'(cnt_d);
   assign drain_r_idx_s = IW'(CW'(WIDTH - 1) - cnt_q);
   assign drain_l_idx_s = IW'(cnt_q);

   // Register control pins, drain reassembly and result reporting.
   always_comb begin
      sr_clear_n_d  = (state_d != CLEAR);
      sr_select_d   = (state_d == CLEAR) ? (dir_q == DIR_R) : sr_select_q;
      sr_serial_r_d = 1'b0;
      sr_serial_l_d = 1'b0;
      if (state_d == LOAD) begin
         if (dir_q == DIR_R) begin
            sr_serial_r_d = word_q[load_r_idx_s];
         end else begin
            sr_serial_l_d = word_q[load_l_idx_s];
         end
      end else begin
         sr_serial_r_d = 1'b0;
      end
      busy_d = (state_d != IDLE);
      acc_d  = acc_q;
      if (state_q == DRAIN) begin
         if (dir_q == DIR_R) begin
            acc_d[drain_r_idx_s] = sr_out;
         end else begin
            acc_d[drain_l_idx_s] = sr_out;
         end
      end else begin
         acc_d = acc_q;
      end
      done_d    = (state_d == DONE);
      rx_data_d = rx_data_q;
      rx_dir_d  = rx_dir_q;
      err_d     = err_q;
      if (state_d == DONE) begin
         rx_data_d = acc_d;
         rx_dir_d  = (dir_q == DIR_R);
         err_d     = (acc_d != word_q);
      end else begin
         rx_data_d = rx_data_q;
      end
   end

   // State and output registers; reset abandons any transfer and clears the register.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q       <= IDLE;
         cnt_q         <= {CW{1'b0}};
         word_q        <= {WIDTH{1'b0}};
         dir_q         <= DIR_L;
         acc_q         <= {WIDTH{1'b0}};
         gnt_r_q       <= 1'b0;
         gnt_l_q       <= 1'b0;
         sr_select_q   <= 1'b0;
         sr_serial_r_q <= 1'b0;
         sr_serial_l_q <= 1'b0;
         sr_clear_n_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         rx_data_q     <= {WIDTH{1'b0}};
         rx_dir_q      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         word_q        <= word_d;
         dir_q         <= dir_d;
         acc_q         <= acc_d;
         gnt_r_q       <= gnt_r_d;
         gnt_l_q       <= gnt_l_d;
         sr_select_q   <= sr_select_d;
         sr_serial_r_q <= sr_serial_r_d;
         sr_serial_l_q <= sr_serial_l_d;
         sr_clear_n_q  <= sr_clear_n_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         rx_data_q     <= rx_data_d;
         rx_dir_q      <= rx_dir_d;
         err_q         <= err_d;
      end
   end

   assign gnt_r       = gnt_r_q;
   assign gnt_l       = gnt_l_q;
   assign sr_select   = sr_select_q;
   assign sr_serial_r = sr_serial_r_q;
   assign sr_serial_l = sr_serial_l_q;
   assign sr_clear_n  = sr_clear_n_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign rx_data     = rx_data_q;
   assign rx_dir      = rx_dir_q;
   assign err         = err_q;

endmodule

// File: tb/tb_bsr_loopback_ctrl.sv
// Bench for bsr_loopback_ctrl with a behavioural bidirectional shift register attached.
module tb_bsr_loopback_ctrl;
   import bsr_ctrl_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         clear_n;
   logic         req_r, req_l;
   logic [W-1:0] data_r, data_l;
   logic         gnt_r, gnt_l;
   logic         sr_select, sr_serial_r, sr_serial_l, sr_clear_n, sr_out;
   logic         busy, done, rx_dir, err;
   logic [W-1:0] rx_data;

   logic [W-1:0] sr_q;
   logic         force_zero;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic         dir;
      logic [W-1:0] rx;
      logic         err;
   } exp_t;

   exp_t sb_q[$];

   typedef struct {
      logic         is_r;
      logic [W-1:0] data;
      logic         f0;
      logic [W-1:0] exp_rx;
      logic         exp_err;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   bsr_loopback_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .clear_n     (clear_n),
      .req_r       (req_r),
      .data_r      (data_r),
      .req_l       (req_l),
      .data_l      (data_l),
      .gnt_r       (gnt_r),
      .gnt_l       (gnt_l),
      .sr_select   (sr_select),
      .sr_serial_r (sr_serial_r),
      .sr_serial_l (sr_serial_l),
      .sr_clear_n  (sr_clear_n),
      .sr_out      (sr_out),
      .busy        (busy),
      .done        (done),
      .rx_data     (rx_data),
      .rx_dir      (rx_dir),
      .err         (err)
   );

   // Shift register: right shift enters at MSB and exits at bit 0; left shift the reverse.
   always @(posedge clk or negedge sr_clear_n) begin
      if (!sr_clear_n) sr_q <= '0;
      else if (sr_select) sr_q <= {sr_serial_r, sr_q[W-1:1]};
      else sr_q <= {sr_q[W-2:0], sr_serial_l};
   end
   assign sr_out = force_zero ? 1'b0 : (sr_select ? sr_q[0] : sr_q[W-1]);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic d, input logic [W-1:0] rx, input logic e);
      exp_t x;
      x.dir = d;
      x.rx  = rx;
      x.err = e;
      sb_q.push_back(x);
   endtask

   // Scoreboard: every done pops the oldest expected result.
   logic done_prev = 1'b0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (clear_n && done) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: done=1 with empty scoreboard at %0t", $time);
         end else begin
            mon_e = sb_q.pop_front();
            check("rx_data", rx_data, mon_e.rx);
            check("rx_dir", rx_dir, mon_e.dir);
            check("err", err, mon_e.err);
         end
         check("done_one_cycle", done_prev, 1'b0);
      end
      done_prev = done;
   end

   task automatic wait_gnt(input logic is_r, input int budget, output int cyc);
      cyc = -1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if ((is_r && gnt_r) || (!is_r && gnt_l)) begin
            cyc = k;
            break;
         end
      end
   endtask

   // One complete transfer with cycle-accurate checks of the register pins.
   task automatic xfer(input vec_t v);
      int c;
      logic [1:0] bi;
      if (v.is_r) begin req_r = 1'b1; data_r = v.data; end
      else begin req_l = 1'b1; data_l = v.data; end
      push_exp(v.is_r, v.exp_rx, v.exp_err);
      wait_gnt(v.is_r, 20, c);
      check("gnt_latency", c, 1);
      check("gnt_other", v.is_r ? gnt_l : gnt_r, 1'b0);
      req_r = 1'b0;
      req_l = 1'b0;
      @(negedge clk);
      check("clear_pulse", sr_clear_n, 1'b0);
      check("busy_active", busy, 1'b1);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check("load_select", sr_select, v.is_r);
         if (v.is_r) begin
            bi = 2'(i);
            check("load_serial_r", sr_serial_r, v.data[bi]);
            check("load_serial_l_idle", sr_serial_l, 1'b0);
         end else begin
            bi = 2'(W - 1 - i);
            check("load_serial_l", sr_serial_l, v.data[bi]);
            check("load_serial_r_idle", sr_serial_r, 1'b0);
         end
      end
      for (int j = 0; j < W; j++) begin
         @(negedge clk);
         force_zero = v.f0;
         check("drain_select", sr_select, v.is_r);
         check("drain_serial", {sr_serial_r, sr_serial_l}, 2'b00);
      end
      @(negedge clk);
      force_zero = 1'b0;
      check("done_latency", done, 1'b1);
      @(negedge clk);
      check("done_end", done, 1'b0);
      check("busy_idle", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int last_cyc;
      int ngr;
      logic exp_r;

      vecs[0] = '{1'b1, 4'b1011, 1'b0, 4'b1011, 1'b0};
      vecs[1] = '{1'b0, 4'b0110, 1'b0, 4'b0110, 1'b0};
      vecs[2] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1};
      vecs[3] = '{1'b0, 4'b1001, 1'b0, 4'b1001, 1'b0};
      vecs[4] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0};
      vecs[5] = '{1'b0, 4'b1000, 1'b1, 4'b0000, 1'b1};

      clear_n = 1'b0; req_r = 1'b0; req_l = 1'b0;
      data_r = '0; data_l = '0; force_zero = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_gnt", {gnt_r, gnt_l}, 2'b00);
      check("rst_busy_done", {busy, done}, 2'b00);
      check("rst_rx", {rx_data, rx_dir, err}, 6'd0);
      check("rst_sr_pins", {sr_select, sr_serial_r, sr_serial_l}, 3'b000);
      check("rst_sr_clear_n", sr_clear_n, 1'b0);
      clear_n = 1'b1;
      @(negedge clk);
      check("idle_sr_clear_n", sr_clear_n, 1'b1);
      check("idle_busy", busy, 1'b0);

      for (int t = 0; t < 6; t++) xfer(vecs[t]);

      // Left request arriving mid-transfer waits for IDLE.
      req_r = 1'b1; data_r = 4'b0110;
      push_exp(1'b1, 4'b0110, 1'b0);
      wait_gnt(1'b1, 20, c);
      check("mid_gnt_r", c, 1);
      req_r = 1'b0;
      repeat (3) @(negedge clk);
      req_l = 1'b1; data_l = 4'b0011;
      push_exp(1'b0, 4'b0011, 1'b0);
      c = -1;
      for (int k = 4; k < 30; k++) begin
         @(negedge clk);
         if (gnt_l) begin c = k; break; end
      end
      check("late_gnt_cycle", c, 11);
      req_l = 1'b0;
      c = -1;
      for (int k = 1; k < 20; k++) begin
         @(negedge clk);
         if (done) begin c = k; break; end
      end
      check("late_done_cycle", c, 10);
      @(negedge clk);

      // Reset during DRAIN abandons the transfer.
      req_r = 1'b1; data_r = 4'b1101;
      push_exp(1'b1, 4'b1101, 1'b0);
      wait_gnt(1'b1, 20, c);
      check("rst_mid_gnt", c, 1);
      req_r = 1'b0;
      repeat (7) @(negedge clk);
      clear_n = 1'b0;
      #1;
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_sr_clear_n", sr_clear_n, 1'b0);
      check("rst_mid_rx_data", rx_data, 4'b0000);
      check("rst_mid_done", done, 1'b0);
      void'(sb_q.pop_back());
      repeat (2) @(negedge clk);
      clear_n = 1'b1;
      @(negedge clk);
      check("rst_rel_sr_clear_n", sr_clear_n, 1'b1);
      check("rst_rel_busy", busy, 1'b0);
      xfer('{1'b1, 4'b0101, 1'b0, 4'b0101, 1'b0});

      // Both channels requesting continuously from a fresh reset.
      clear_n = 1'b0;
      @(negedge clk);
      clear_n = 1'b1;
      @(negedge clk);
      req_r = 1'b1; data_r = 4'b1010;
      req_l = 1'b1; data_l = 4'b0101;
      last_cyc = -1; ngr = 0; exp_r = 1'b1;
      for (int k = 0; k < 80 && ngr < 4; k++) begin
         @(negedge clk);
         if (gnt_r || gnt_l) begin
            check("rr_winner", gnt_r, exp_r);
            check("rr_single", gnt_r & gnt_l, 1'b0);
            if (ngr > 0) check("rr_spacing", k - last_cyc, 11);
            push_exp(exp_r, exp_r ? 4'b1010 : 4'b0101, 1'b0);
            last_cyc = k;
            exp_r = ~exp_r;
            ngr++;
         end
      end
      req_r = 1'b0; req_l = 1'b0;
      check("rr_grants", ngr, 4);
      for (int k = 0; k < 40; k++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      check("sb_drained", sb_q.size(), 0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bsr_loopback_ctrl.md
# bsr_loopback_ctrl

Sequencer and arbiter for the 4-bit bidirectional serial-in/serial-out shift register. Two requesters (right-channel, left-channel) each submit a parallel word. The block grants one requester round-robin, clears the register, and serializes the word into it in that channel's direction. It then drains the register, reassembles the word from the serial output, and reports it with a mismatch flag. It is the loopback/self-test front end that owns the register's control pins.

## Interface
Parameters:
- `WIDTH`, 4: shift-register depth and word width; must match the attached register.

Ports:
- `clk`  in  1  rising-edge clock, shared with the shift register.
- `clear_n`  in  1  asynchronous active-low reset.
- `req_r`  in  1  right-channel request, held until `gnt_r`.
- `data_r`  in  WIDTH  right-channel word, valid while `req_r`.
- `req_l`  in  1  left-channel request, held until `gnt_l`.
- `data_l`  in  WIDTH  left-channel word, valid while `req_l`.
- `gnt_r`, `gnt_l`  out  1  one-cycle grant pulse; data is captured at this edge.
- `sr_select`  out  1  drives register `select`: 1 = right shift, 0 = left shift.
- `sr_serial_r`, `sr_serial_l`  out  1  drive register serial inputs.
- `sr_clear_n`  out  1  drives register `clear_n`.
- `sr_out`  in  1  register `out`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse: `rx_data`, `rx_dir` and `err` are valid.
- `rx_data`  out  WIDTH  reassembled word, held until the next `done`.
- `rx_dir`  out  1  channel of the last transfer: 1 = R, 0 = L.
- `err`  out  1  `rx_data` differs from the captured word; valid with `done` and held.

## Operation
- States: IDLE → CLEAR → LOAD → DRAIN → DONE → IDLE.
- IDLE: if any request is present, grant one, capture its word and direction, and go to CLEAR.
- Arbitration is round-robin. If both channels request, the channel not granted last wins. The first tie after reset goes to R.
- CLEAR, 1 cycle: `sr_clear_n`=0.
- LOAD, WIDTH cycles: `sr_select`=dir.
  - R direction: `sr_serial_r` = word[i], LSB first (i = 0..WIDTH-1).
  - L direction: `sr_serial_l` = word[WIDTH-1-i], MSB first.
  - The inactive serial input is held at 0.
- DRAIN, WIDTH cycles: `sr_select`=dir and both serial inputs are 0. `sr_out` is sampled every cycle at the closing edge, i.e. the pre-shift value.
  - R: sample j goes to `rx_data`[j].
  - L: sample j goes to `rx_data`[WIDTH-1-j].
  - With a correct register this reproduces the captured word.
- DONE, 1 cycle: pulse `done`, update `rx_dir`, set `err` = (`rx_data` != word). Then return to IDLE; a new grant is possible in the following cycle.
- A single 3-bit down-counter, width clog2(WIDTH)+1, indexes LOAD and DRAIN and reloads on each state entry.
- Requests arriving while busy are ignored until IDLE; requesters hold `req`.
- Reset mid-operation abandons the transfer, with no `done` and no grant.

## Timing
- Reset values:
  - State IDLE, last-grant = L (so R wins the first tie).
  - `gnt_r`=`gnt_l`=0, `busy`=0, `done`=0, `err`=0, `rx_data`=0, `rx_dir`=0.
  - `sr_select`=0, both serial outputs 0.
  - `sr_clear_n`=0 while `clear_n` is low, forcing the register clear; it is 1 in IDLE afterwards.
- All outputs are registered. The grant edge is cycle 0: CLEAR occupies cycle 1, LOAD cycles 2..WIDTH+1, DRAIN cycles WIDTH+2..2·WIDTH+1, DONE cycle 2·WIDTH+2.
- Request-to-done latency is 2·WIDTH+3 cycles, 11 for WIDTH=4.
- `sr_select` is stable for the whole LOAD and DRAIN span and changes only in CLEAR or IDLE.

## Structure
- Package `bsr_ctrl_pkg`:
  - `typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, DONE} bsr_state_t`
  - `typedef enum logic {DIR_L=0, DIR_R=1} bsr_dir_t`
  - `localparam BSR_WIDTH=4`
- Sub-module `rr_arb2`: two-request round-robin arbiter with a last-grant register, updated only on grant.
- The top level instantiates `rr_arb2`; the bench instantiates the existing shift register alongside the controller.

## Test plan
- R only, `data_r`=4'b1011 → `gnt_r` at cycle 0, 4 LOAD cycles with `sr_serial_r` = 1,1,0,1, `done` at cycle 10, `rx_data`=4'b1011, `rx_dir`=1, `err`=0.
- L only, `data_l`=4'b0110 → `sr_serial_l` = 0,1,1,0, `sr_select`=0 throughout, `rx_data`=4'b0110, `rx_dir`=0, `err`=0.
- Both requesting continuously from reset → grants alternate R, L, R, L; `done` every 11 cycles; `rx_dir` alternates.
- Reset asserted in DRAIN (cycle 7) → `busy` and `sr_clear_n` fall immediately, no `done`, `rx_data` reads 0. After release, the next R request completes normally.
- Register output forced to 0 during DRAIN, `data_r`=4'b1111 → `rx_data`=0, `err`=1.
- `req_l` rises mid-transfer → ignored until IDLE, then granted in the cycle after `done`.
